alu_sequencer: RTL and testbench
================================

# alu_sequencer

- Upstream control stage for the 16-bit ALU: accepts 16-bit instructions over a valid/ready handshake and holds a 4×16 register file.
- Drives the ALU operand/control inputs (`ina`, `inb`, `alucnt`) from registers, samples the ALU's registered result one cycle later, writes it back and reports it.
- Serialises instructions, so there are no operand hazards.

## Interface
Parameters:
- `NREG`, 4: register-file depth (rd/rs fields are 2 bits; only 4 is supported).
- `W`, 16: datapath width.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset. Clock `clk`; reset `rst`, synchronous, active-high.
- `instr` in 16: instruction word.
- `instr_valid` in 1: `instr` is valid this cycle.
- `instr_ready` out 1: the block accepts `instr` this cycle.
- `ina` out 16: ALU operand A, registered.
- `inb` out 16: ALU operand B, registered.
- `alucnt` out 2: ALU function, registered (00 add, 01 sub, 10 and, 11 or).
- `alu_out` in 16: ALU registered result.
- `res_valid` out 1: one-cycle pulse; `res_data` is written back.
- `res_data` out 16: value written to `rf[rd]`.
- `err` out 1: one-cycle pulse on an illegal opcode.
- `dbg_addr` in 2: debug register-file read address.
- `dbg_data` out 16: combinational `rf[dbg_addr]`.

## Operation
Instruction fields:
- `[15:12]` opcode, `[11:10]` rd, `[9:8]` rs1, `[7:6]` rs2, `[7:0]` imm8 (LDI only).

Opcodes:
- 0000 NOP.
- 0001 ADD, 0010 SUB, 0011 AND, 0100 OR: `alucnt` = opcode−1.
- 0101 LDI: `rd` ← zero-extended imm8.
- 0110–1111: illegal.

Handshake:
- Accept when `instr_valid && instr_ready`.
- `instr_ready` = (state==IDLE) && !`rst`.
- `instr` is ignored when not accepted.

FSM states IDLE, EXEC, WB:
- **IDLE, ALU op accepted:** `ina`←`rf[rs1]`, `inb`←`rf[rs2]`, `alucnt` set, rd latched; go to EXEC.
- **IDLE, LDI accepted:** `rf[rd]`←imm8 at the acceptance edge; `res_valid`=1 and `res_data`=imm8 next cycle; stay in IDLE.
- **IDLE, NOP accepted:** no effect; stay in IDLE.
- **IDLE, illegal accepted:** `err`=1 next cycle; no register write; stay in IDLE.
- **EXEC:** operands held stable (the ALU captures them at this edge); go to WB.
- **WB:** `rf[rd]`←`alu_out`, `res_data`←`alu_out`, `res_valid`←1 at this edge; go to IDLE.

Rules:
- `alu_out` is sampled only in WB.
- `ina`, `inb` and `alucnt` hold their last values in IDLE.
- Arithmetic wraps modulo 2^16; there is no carry or overflow flag. SUB is `rf[rs1]`−`rf[rs2]`.
- rd may equal rs1 or rs2: the operands are read at acceptance, before any write.

## Timing
Reset (`rst` high at an edge):
- state=IDLE.
- All `rf` entries = 0.
- `ina`=`inb`=0, `alucnt`=00.
- `res_valid`=0, `res_data`=0, `err`=0.

Reset mid-operation:
- Abandons the EXEC/WB instruction; no write-back and no `res_valid`.
- `instr_ready`=1 on the first cycle after `rst` falls.

ALU op:
- Accepted at edge E0, EXEC during E0→E1, WB during E1→E2.
- `res_valid` is high in the cycle after E2.
- Next accept is possible at E2's following edge, since `instr_ready` is high from E2 on.
- Throughput is 1 ALU op per 3 cycles.

LDI/NOP/illegal:
- 1 cycle each; back-to-back accepts are allowed.
- `res_valid`/`err` pulses are one cycle wide per instruction.

`dbg_data` reflects a write in the cycle after the write edge.

## Structure
- Package `alu_seq_pkg`:
  - opcode constants (OP_NOP…OP_LDI);
  - `alucnt` constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR);
  - FSM state encoding (S_IDLE, S_EXEC, S_WB).
- Sub-module `alu_seq_regfile`:
  - 4×16 storage;
  - one synchronous write port, three combinational read ports (rs1, rs2, dbg);
  - synchronous reset to 0.
- The top level holds the FSM, the operand/control registers, the rd latch and the pulse outputs.
- The bench instantiates the ALU alongside this block, with `alu_out` fed back.

## Test plan
- Reset, then read all `dbg_addr` → 0.
  - `instr_ready`=1, `ina`=`inb`=0, `alucnt`=00, `res_valid`=`err`=0.
- LDI r1,0x34; LDI r2,0x12; ADD r3,r1,r2.
  - `res_valid` pulses with 0x0034, then 0x0012, then 0x0046 (3 cycles after the ADD accept); `dbg` r3=0x0046.
- LDI r0,0x01; LDI r1,0x02; SUB r2,r0,r1 → `res_data`=0xFFFF (wrap).
  - LDI r1,0xF0; AND r3,r2,r1 → 0x00F0; OR r3,r3,r0 → 0x00F1 (rd==rs1).
- `instr_valid` held high with an ADD stream.
  - `instr_ready` pattern is 1,0,0 repeating; exactly one accept per 3 cycles.
  - `ina`, `inb` and `alucnt` are stable during EXEC.
- Opcode 0xA issued → `err` pulse for 1 cycle.
  - No `res_valid`; all registers unchanged.
  - NOP → nothing changes.
- `rst` asserted during EXEC of ADD r0,r1,r2 with r0 nonzero.
  - No `res_valid`; r0=0 after reset; `instr_ready` returns the cycle after `rst` falls.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: opcodes, ALU function codes, FSM states.
package alu_seq_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_WB   = 2'b10
    } state_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file for the ALU sequencer: one synchronous write port, three
// combinational read ports (two operands and a debug tap).
module alu_seq_regfile #(
    parameter int NREG = 4,
    parameter int W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [1:0]   waddr,
    input  logic [W-1:0] wdata,
    input  logic [1:0]   ra1,
    output logic [W-1:0] rd1,
    input  logic [1:0]   ra2,
    output logic [W-1:0] rd2,
    input  logic [1:0]   ra3,
    output logic [W-1:0] rd3
);

    logic [W-1:0] rf [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (we) begin
            rf[waddr] <= wdata;
        end
    end

    assign rd1 = rf[ra1];
    assign rd2 = rf[ra2];
    assign rd3 = rf[ra3];

endmodule

// File: rtl/alu_sequencer.sv
// Control stage in front of a registered 16-bit ALU: decodes instructions,
// drives ALU operands from the register file and writes the result back.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NREG = 4,
    parameter int W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  instr,
    input  logic         instr_valid,
    output logic         instr_ready,
    output logic [W-1:0] ina,
    output logic [W-1:0] inb,
    output logic [1:0]   alucnt,
    input  logic [W-1:0] alu_out,
    output logic         res_valid,
    output logic [W-1:0] res_data,
    output logic         err,
    input  logic [1:0]   dbg_addr,
    output logic [W-1:0] dbg_data
);

    state_t       state;
    logic [1:0]   rd_q;
    logic         accept;
    logic [3:0]   op;
    logic [1:0]   rd_f;
    logic [1:0]   rs1_f;
    logic [1:0]   rs2_f;
    logic [W-1:0] imm_ext;
    logic [W-1:0] rs1_data;
    logic [W-1:0] rs2_data;
    logic         rf_we;
    logic [1:0]   rf_waddr;
    logic [W-1:0] rf_wdata;

    assign op      = instr[15:12];
    assign rd_f    = instr[11:10];
    assign rs1_f   = instr[9:8];
    assign rs2_f   = instr[7:6];
    assign imm_ext = W'(instr[7:0]);

    assign instr_ready = (state == S_IDLE) && !rst;
    assign accept      = instr_valid && instr_ready;

    // LDI writes at its acceptance edge; ALU results are written in WB.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rd_q;
        rf_wdata = alu_out;
        if (state == S_WB) begin
            rf_we = 1'b1;
        end else if (accept && op == OP_LDI) begin
            rf_we    = 1'b1;
            rf_waddr = rd_f;
            rf_wdata = imm_ext;
        end
    end

    alu_seq_regfile #(.NREG(NREG), .W(W)) u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (rf_we),
        .waddr (rf_waddr),
        .wdata (rf_wdata),
        .ra1   (rs1_f),
        .rd1   (rs1_data),
        .ra2   (rs2_f),
        .rd2   (rs2_data),
        .ra3   (dbg_addr),
        .rd3   (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ina       <= '0;
            inb       <= '0;
            alucnt    <= ALU_ADD;
            rd_q      <= 2'd0;
            res_valid <= 1'b0;
            res_data  <= '0;
            err       <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            err       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                                ina   <= rs1_data;
                                inb   <= rs2_data;
                                rd_q  <= rd_f;
                                state <= S_EXEC;
                                case (op)
                                    OP_ADD:  alucnt <= ALU_ADD;
                                    OP_SUB:  alucnt <= ALU_SUB;
                                    OP_AND:  alucnt <= ALU_AND;
                                    default: alucnt <= ALU_OR;
                                endcase
                            end
                            OP_LDI: begin
                                res_valid <= 1'b1;
                                res_data  <= imm_ext;
                            end
                            OP_NOP: ;
                            default: err <= 1'b1;
                        endcase
                    end
                end
                // ALU captures the held operands at the end of this cycle.
                S_EXEC: state <= S_WB;
                S_WB: begin
                    res_valid <= 1'b1;
                    res_data  <= alu_out;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a registered ALU model in the loop.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = 16'h0000;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] ina, inb;
    logic [1:0]  alucnt;
    logic [15:0] alu_out = 16'h0000;
    logic        res_valid;
    logic [15:0] res_data;
    logic        err;
    logic [1:0]  dbg_addr = 2'd0;
    logic [15:0] dbg_data;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        bit          is_err;
        logic [15:0] data;
        int          due;
    } exp_t;
    exp_t q[$];

    alu_sequencer #(.NREG(4), .W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .ina         (ina),
        .inb         (inb),
        .alucnt      (alucnt),
        .alu_out     (alu_out),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .err         (err),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered ALU: result appears one cycle after operands are presented.
    always @(posedge clk) begin
        case (alucnt)
            2'b00:   alu_out <= ina + inb;
            2'b01:   alu_out <= ina - inb;
            2'b10:   alu_out <= ina & inb;
            default: alu_out <= ina | inb;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per res_valid/err pulse.
    always @(negedge clk) begin
        if (rst === 1'b0 && (res_valid === 1'b1 || err === 1'b1)) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: res_valid=%b err=%b data=%h expected none", res_valid, err, res_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pulse_cycle", cyc, e.due);
                check("err_flag", {31'd0, err}, {31'd0, e.is_err});
                check("res_valid_flag", {31'd0, res_valid}, {31'd0, !e.is_err});
                if (!e.is_err) check("res_data", {16'd0, res_data}, {16'd0, e.data});
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [15:0] ins, input bit resp, input bit is_err,
                        input logic [15:0] data, input int lat);
        int waited;
        waited = 0;
        instr = ins;
        instr_valid = 1'b1;
        #1;
        while (instr_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (instr_ready !== 1'b1) begin
            check("accept_timeout", {31'd0, instr_ready}, 32'd1);
        end else begin
            if (resp) q.push_back('{is_err, data, cyc + lat});
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic rf_check(input string name, input logic [1:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        check(name, {16'd0, dbg_data}, {16'd0, exp});
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_ina", {16'd0, ina}, 32'd0);
        check("rst_inb", {16'd0, inb}, 32'd0);
        check("rst_alucnt", {30'd0, alucnt}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        for (int i = 0; i < 4; i++) rf_check("rst_rf", 2'(i), 16'h0000);
        @(negedge clk);

        // LDI r1,0x34; LDI r2,0x12; ADD r3,r1,r2
        send(16'h5434, 1, 0, 16'h0034, 1);
        send(16'h5812, 1, 0, 16'h0012, 1);
        send(16'h1D80, 1, 0, 16'h0046, 3);
        idle(4);
        rf_check("add_r3", 2'd3, 16'h0046);

        // SUB wrap, AND, OR with rd==rs1
        send(16'h5001, 1, 0, 16'h0001, 1);
        send(16'h5402, 1, 0, 16'h0002, 1);
        send(16'h2840, 1, 0, 16'hFFFF, 3);
        send(16'h54F0, 1, 0, 16'h00F0, 1);
        send(16'h3E40, 1, 0, 16'h00F0, 3);
        send(16'h4F00, 1, 0, 16'h00F1, 3);
        idle(4);
        rf_check("sub_r2", 2'd2, 16'hFFFF);
        rf_check("or_r3", 2'd3, 16'h00F1);

        // Held-valid ADD r3,r0,r1 stream: ready 1,0,0 and stable operands
        instr = 16'h1C40;
        instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stream_ready_idle", {31'd0, instr_ready}, 32'd1);
            q.push_back('{1'b0, 16'h00F1, cyc + 3});
            for (int s = 0; s < 2; s++) begin
                @(posedge clk);
                @(negedge clk);
                #1;
                check("stream_ready_busy", {31'd0, instr_ready}, 32'd0);
                check("stream_ina", {16'd0, ina}, 32'h0001);
                check("stream_inb", {16'd0, inb}, 32'h00F0);
                check("stream_alucnt", {30'd0, alucnt}, 32'd0);
            end
            @(posedge clk);
            @(negedge clk);
        end
        idle(4);

        // Illegal opcode, then NOP: registers untouched
        send(16'hA000, 1, 1, 16'h0000, 1);
        send(16'h0000, 0, 0, 16'h0000, 0);
        idle(4);
        rf_check("keep_r0", 2'd0, 16'h0001);
        rf_check("keep_r1", 2'd1, 16'h00F0);
        rf_check("keep_r2", 2'd2, 16'hFFFF);
        rf_check("keep_r3", 2'd3, 16'h00F1);

        // Reset during EXEC of ADD r0,r1,r2
        send(16'h1180, 0, 0, 16'h0000, 0);
        instr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_ready", {31'd0, instr_ready}, 32'd1);
        rf_check("midrst_r0", 2'd0, 16'h0000);
        idle(6);
        rf_check("midrst_r0_late", 2'd0, 16'h0000);

        check("queue_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
        $fatal(1);
    end

endmodule
